// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv-layer datapath blocks.
// Clamp bounds are derived from the output width so layer 1 can reuse them.
package conv_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Narrowest accumulator that cannot wrap when summing n signed in_w values plus a bias.
    function automatic int unsigned acc_w_min(input int unsigned in_w, input int unsigned n);
        return in_w + 32'($clog2(n)) + 32'd1;
    endfunction

    function automatic int out_max(input int unsigned w);
        return (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    endfunction

    function automatic int out_min(input int unsigned w);
        return -(32'sd1 <<< (w - 32'd1));
    endfunction

    localparam int unsigned OUT_W_DFLT = 16;
    localparam int          OUT_MAX    = out_max(OUT_W_DFLT);
    localparam int          OUT_MIN    = out_min(OUT_W_DFLT);

endpackage

// File: rtl/conv2_channel_accumulator_if.sv
// Stream port between adder stage 2, the channel accumulator and the pooling stage.
interface conv2_channel_accumulator_if #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 16
);
    logic signed [IN_W-1:0]  input1;
    logic                    enable;
    logic signed [OUT_W-1:0] bias;
    logic                    flush;
    logic signed [OUT_W-1:0] output1;
    logic                    done;
    logic                    sat;

    modport master (
        output input1, enable, bias, flush,
        input  output1, done, sat
    );

    modport slave (
        input  input1, enable, bias, flush,
        output output1, done, sat
    );
endinterface

// File: rtl/sat_round_relu.sv
// Combinational clamp of a wide signed value to OUT_W with a clamp flag.
// ReLU after the clamp is enabled by defining CONV2_ACC_RELU_EN.
module sat_round_relu
    import conv_pkg::*;
#(
    parameter int unsigned IN_W  = 24,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout_c,
    output logic                    sat_c
);

    localparam logic signed [IN_W-1:0]  HI_LIM = IN_W'(out_max(OUT_W));
    localparam logic signed [IN_W-1:0]  LO_LIM = IN_W'(out_min(OUT_W));
    localparam logic signed [OUT_W-1:0] HI_OUT = OUT_W'(out_max(OUT_W));
    localparam logic signed [OUT_W-1:0] LO_OUT = OUT_W'(out_min(OUT_W));

    always_comb begin
        sat_c  = 1'b0;
        dout_c = din[OUT_W-1:0];
        if (din > HI_LIM) begin
            dout_c = HI_OUT;
            sat_c  = 1'b1;
        end else if (din < LO_LIM) begin
            dout_c = LO_OUT;
            sat_c  = 1'b1;
        end
`ifdef CONV2_ACC_RELU_EN
        // sat keeps reporting the clamp even when ReLU zeroes the value
        if (dout_c[OUT_W-1]) begin
            dout_c = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/conv2_channel_accumulator.sv
// Sums NUM_CHANNELS partial sums plus bias per pixel, then clamps to OUT_W.
// Optional ReLU on the output: define CONV2_ACC_RELU_EN.
module conv2_channel_accumulator
    import conv_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned IN_W         = 18,
    parameter int unsigned OUT_W        = 16,
    parameter int unsigned ACC_W        = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    conv2_channel_accumulator_if.slave  bus
);

    localparam int unsigned       CNT_W    = $clog2(NUM_CHANNELS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_CHANNELS - 1);

    if (ACC_W < acc_w_min(IN_W, NUM_CHANNELS)) begin : g_acc_w_check
        $error("ACC_W too narrow for IN_W and NUM_CHANNELS");
    end

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;

    logic signed [ACC_W-1:0] sum_c;
    logic                    last_c;
    logic signed [OUT_W-1:0] clamp_c;
    logic                    clamp_sat_c;

    // Beat sum and last-beat detect; the first beat folds in the bias.
    always_comb begin
        sum_c  = acc_q + ACC_W'(bus.input1);
        last_c = 1'b0;
        if (state_q == IDLE) begin
            sum_c = ACC_W'(bus.bias) + ACC_W'(bus.input1);
            if (NUM_CHANNELS == 1) begin
                last_c = bus.enable;
            end
        end else if (cnt_q == LAST_CNT) begin
            last_c = bus.enable;
        end
    end

    sat_round_relu #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .din    (sum_c),
        .dout_c (clamp_c),
        .sat_c  (clamp_sat_c)
    );

    // Next-state: enable wins over flush; idle cycles hold acc and count.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        sat_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    if (!last_c) begin
                        acc_d   = sum_c;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end
                end else if (bus.flush) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            ACCUM: begin
                if (bus.enable) begin
                    if (!last_c) begin
                        acc_d = sum_c;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (bus.flush) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (last_c) begin
            out_d   = clamp_c;
            sat_d   = clamp_sat_c;
            done_d  = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.output1 = out_q;
    assign bus.done    = done_q;
    assign bus.sat     = sat_q;

endmodule

// File: tb/tb_conv2_channel_accumulator.sv
// Directed bench for conv2_channel_accumulator (NUM_CHANNELS=3), honours CONV2_ACC_RELU_EN.
module tb_conv2_channel_accumulator;
    import conv_pkg::*;

    localparam int unsigned IN_W  = 18;
    localparam int unsigned OUT_W = 16;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   done_seen;

    conv2_channel_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    conv2_channel_accumulator #(
        .NUM_CHANNELS (3),
        .IN_W         (IN_W),
        .OUT_W        (OUT_W),
        .ACC_W        (24)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) done_seen++;
    endtask

    task automatic beat(input int v);
        bus.enable = 1'b1;
        bus.input1 = IN_W'(v);
        step();
        bus.enable = 1'b0;
    endtask

    task automatic idle();
        bus.enable = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.flush  = 1'b0;
        bus.bias   = '0;
        bus.input1 = '0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (bus.output1 !== 16'sd0) begin errors++; $display("FAIL reset_output1 got %0d exp 0", bus.output1); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++;
        if (bus.sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", bus.sat); end
    endtask

    task automatic test_basic();
        done_seen = 0;
        bus.bias = 16'sd0;
        beat(100);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_early_done1 got %b exp 0", bus.done); end
        beat(-50);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_early_done2 got %b exp 0", bus.done); end
        beat(25);
        checks++;
        if (bus.output1 !== 16'sd75) begin errors++; $display("FAIL basic_output1 got %0d exp 75", bus.output1); end
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", bus.done); end
        checks++;
        if (bus.sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b exp 0", bus.sat); end
        idle();
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_drop got %b exp 0", bus.done); end
        checks++;
        if (bus.output1 !== 16'sd75) begin errors++; $display("FAIL basic_hold got %0d exp 75", bus.output1); end
    endtask

    task automatic test_bias_gaps();
        done_seen = 0;
        bus.bias = 16'sd10;
        beat(1);
        bus.bias = 16'sd99;   // later beats must not resample bias
        idle(); idle();
        beat(2);
        idle(); idle();
        beat(3);
        checks++;
        if (bus.output1 !== 16'sd16) begin errors++; $display("FAIL gaps_output1 got %0d exp 16", bus.output1); end
        idle(); idle();
        checks++;
        if (done_seen !== 1) begin errors++; $display("FAIL gaps_done_count got %0d exp 1", done_seen); end
        bus.bias = 16'sd0;
    endtask

    task automatic test_pos_sat();
        beat(100000); beat(100000); beat(100000);
        checks++;
        if (bus.output1 !== 16'sd32767) begin errors++; $display("FAIL possat_output1 got %0d exp 32767", bus.output1); end
        checks++;
        if (bus.sat !== 1'b1 || bus.done !== 1'b1) begin errors++; $display("FAIL possat_flags got sat=%b done=%b exp 1 1", bus.sat, bus.done); end
        idle();
        checks++;
        if (bus.sat !== 1'b0) begin errors++; $display("FAIL possat_sat_drop got %b exp 0", bus.sat); end
    endtask

    task automatic test_neg_sat();
        logic signed [OUT_W-1:0] exp_v;
`ifdef CONV2_ACC_RELU_EN
        exp_v = 16'sd0;
`else
        exp_v = OUT_W'(OUT_MIN);
`endif
        beat(-100000); beat(-100000); beat(-100000);
        checks++;
        if (bus.output1 !== exp_v) begin errors++; $display("FAIL negsat_output1 got %0d exp %0d", bus.output1, exp_v); end
        checks++;
        if (bus.sat !== 1'b1) begin errors++; $display("FAIL negsat_sat got %b exp 1", bus.sat); end
        idle();
    endtask

    task automatic test_back_to_back();
        done_seen = 0;
        beat(1); beat(2); beat(3);
        checks++;
        if (bus.output1 !== 16'sd6 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first got %0d done=%b exp 6 done=1", bus.output1, bus.done); end
        beat(4);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_gap_done got %b exp 0", bus.done); end
        beat(5); beat(6);
        checks++;
        if (bus.output1 !== 16'sd15 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second got %0d done=%b exp 15 done=1", bus.output1, bus.done); end
        idle();
        checks++;
        if (done_seen !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_seen); end
    endtask

    task automatic test_flush_with_enable();
        beat(5);
        bus.flush = 1'b1;
        beat(7);
        bus.flush = 1'b0;
        beat(1);
        checks++;
        if (bus.output1 !== 16'sd13 || bus.done !== 1'b1) begin errors++; $display("FAIL flush_en_ignored got %0d done=%b exp 13 done=1", bus.output1, bus.done); end
        idle();
    endtask

    task automatic test_flush();
        done_seen = 0;
        beat(5); beat(7);
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done got %b exp 0", bus.done); end
        beat(1); beat(1); beat(1);
        checks++;
        if (bus.output1 !== 16'sd3 || bus.done !== 1'b1) begin errors++; $display("FAIL flush_output1 got %0d done=%b exp 3 done=1", bus.output1, bus.done); end
        idle();
        checks++;
        if (done_seen !== 1) begin errors++; $display("FAIL flush_done_count got %0d exp 1", done_seen); end
    endtask

    task automatic test_reset_abort();
        done_seen = 0;
        beat(5); beat(7);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.output1 !== 16'sd0) begin errors++; $display("FAIL rstab_clear got %0d done=%b exp 0 done=0", bus.output1, bus.done); end
        beat(1); beat(1); beat(1);
        checks++;
        if (bus.output1 !== 16'sd3 || bus.done !== 1'b1) begin errors++; $display("FAIL rstab_output1 got %0d done=%b exp 3 done=1", bus.output1, bus.done); end
        idle();
        checks++;
        if (done_seen !== 1) begin errors++; $display("FAIL rstab_done_count got %0d exp 1", done_seen); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        done_seen = 0;
        test_reset();
        test_basic();
        test_bias_gaps();
        test_pos_sat();
        test_neg_sat();
        test_back_to_back();
        test_flush_with_enable();
        test_flush();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
